// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: produces per-register stall/flush controls for the
// 5-stage core from RAW hazards, EX redirects, data-memory waits and HALT drain.
module hazard_ctrl #(
   parameter int FORWARDING = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       Rs10_8_dec,
   input  logic [2:0]       Rt7_5_dec,
   input  logic             uses_rs_dec,
   input  logic             uses_rt_dec,
   input  logic [2:0]       Rd_ex,
   input  logic             REGWRITE_ex,
   input  logic             MEMREAD_ex,
   input  logic [2:0]       Rd_mem,
   input  logic             REGWRITE_mem,
   input  logic             redirect_ex,
   input  logic             HALT_ex,
   input  logic             dmem_busy,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             stall_idex,
   output logic             stall_exmem,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_memwb,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {RUN, DSTALL, MWAIT, HALTED} state_t;

   state_t           state_q, state_d, effState;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       need;
   logic             mdEx, mdMem;
   logic             spC, siC, sxC, seC, fiC, fxC, fmC;

   assign mdEx  = REGWRITE_ex  & ((uses_rs_dec & (Rs10_8_dec == Rd_ex))  |
                                  (uses_rt_dec & (Rt7_5_dec  == Rd_ex)));
   assign mdMem = REGWRITE_mem & ((uses_rs_dec & (Rs10_8_dec == Rd_mem)) |
                                  (uses_rt_dec & (Rt7_5_dec  == Rd_mem)));

   always_comb begin
      need = 2'd0;
      if (FORWARDING != 0) begin
         if (mdEx && MEMREAD_ex) need = 2'd1;
      end else begin
         if (mdEx)       need = 2'd2;
         else if (mdMem) need = 2'd1;
      end
   end

   // A wait that just ended behaves this same cycle like the state it resumes,
   // so the held decode instruction is neither skipped nor given an extra gap.
   always_comb begin
      effState = state_q;
      if (state_q == MWAIT && !dmem_busy)
         effState = (bcnt_q != 2'd0) ? DSTALL : RUN;
   end

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      spC = 1'b0; siC = 1'b0; sxC = 1'b0; seC = 1'b0;
      fiC = 1'b0; fxC = 1'b0; fmC = 1'b0;
      if (state_q == HALTED) begin
         spC = 1'b1; fiC = 1'b1; fxC = 1'b1;
         if (dmem_busy) begin
            seC = 1'b1; fmC = 1'b1;
         end
      end else if (dmem_busy) begin
         spC = 1'b1; siC = 1'b1; sxC = 1'b1; seC = 1'b1; fmC = 1'b1;
         state_d = MWAIT;
      end else if (redirect_ex) begin
         fiC = 1'b1; fxC = 1'b1;
         bcnt_d  = 2'd0;
         state_d = RUN;
      end else if (HALT_ex) begin
         spC = 1'b1; fiC = 1'b1; fxC = 1'b1;
         bcnt_d  = 2'd0;
         state_d = HALTED;
      end else if (effState == DSTALL) begin
         spC = 1'b1; siC = 1'b1; fxC = 1'b1;
         bcnt_d  = bcnt_q - 2'd1;
         state_d = (bcnt_q == 2'd1) ? RUN : DSTALL;
      end else if (need != 2'd0) begin
         spC = 1'b1; siC = 1'b1; fxC = 1'b1;
         bcnt_d  = need - 2'd1;
         state_d = (need > 2'd1) ? DSTALL : RUN;
      end else begin
         state_d = RUN;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (spC && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         bcnt_q  <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are forced low for as long as reset is held.
   assign stall_pc     = rst & spC;
   assign stall_ifid   = rst & siC;
   assign stall_idex   = rst & sxC;
   assign stall_exmem  = rst & seC;
   assign flush_ifid   = rst & fiC;
   assign flush_idex   = rst & fxC;
   assign flush_memwb  = rst & fmC;
   assign halted       = rst & (state_q == HALTED);
   assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a forwarding and a non-forwarding instance
// share stimulus and are compared each cycle against a bubble-count reference model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] Rs10_8_dec = '0, Rt7_5_dec = '0, Rd_ex = '0, Rd_mem = '0;
   logic       uses_rs_dec = 0, uses_rt_dec = 0, REGWRITE_ex = 0, MEMREAD_ex = 0;
   logic       REGWRITE_mem = 0, redirect_ex = 0, HALT_ex = 0, dmem_busy = 0;

   // Output vectors ordered {stall_pc, stall_ifid, stall_idex, stall_exmem,
   // flush_ifid, flush_idex, flush_memwb, halted}; index 0 = forwarding build.
   logic [7:0] outF, outN;
   logic [3:0] cntF, cntN;

   int vectors     = 0;
   int miscompares = 0;

   bit mHalt[2];
   int mPend[2];
   int mCnt[2];

   always #5 clk = ~clk;

   hazard_ctrl #(.FORWARDING(1), .CNT_W(4)) dutF (
      .clk(clk), .rst(rst),
      .Rs10_8_dec(Rs10_8_dec), .Rt7_5_dec(Rt7_5_dec),
      .uses_rs_dec(uses_rs_dec), .uses_rt_dec(uses_rt_dec),
      .Rd_ex(Rd_ex), .REGWRITE_ex(REGWRITE_ex), .MEMREAD_ex(MEMREAD_ex),
      .Rd_mem(Rd_mem), .REGWRITE_mem(REGWRITE_mem),
      .redirect_ex(redirect_ex), .HALT_ex(HALT_ex), .dmem_busy(dmem_busy),
      .stall_pc(outF[7]), .stall_ifid(outF[6]), .stall_idex(outF[5]),
      .stall_exmem(outF[4]), .flush_ifid(outF[3]), .flush_idex(outF[2]),
      .flush_memwb(outF[1]), .halted(outF[0]), .stall_cycles(cntF)
   );

   hazard_ctrl #(.FORWARDING(0), .CNT_W(4)) dutN (
      .clk(clk), .rst(rst),
      .Rs10_8_dec(Rs10_8_dec), .Rt7_5_dec(Rt7_5_dec),
      .uses_rs_dec(uses_rs_dec), .uses_rt_dec(uses_rt_dec),
      .Rd_ex(Rd_ex), .REGWRITE_ex(REGWRITE_ex), .MEMREAD_ex(MEMREAD_ex),
      .Rd_mem(Rd_mem), .REGWRITE_mem(REGWRITE_mem),
      .redirect_ex(redirect_ex), .HALT_ex(HALT_ex), .dmem_busy(dmem_busy),
      .stall_pc(outN[7]), .stall_ifid(outN[6]), .stall_idex(outN[5]),
      .stall_exmem(outN[4]), .flush_ifid(outN[3]), .flush_idex(outN[2]),
      .flush_memwb(outN[1]), .halted(outN[0]), .stall_cycles(cntN)
   );

   // Does the decode instruction read register r?
   function automatic bit reads(input logic [2:0] r);
      return (uses_rs_dec && Rs10_8_dec == r) || (uses_rt_dec && Rt7_5_dec == r);
   endfunction

   // Bubbles the decode instruction needs before it may leave decode.
   function automatic int bubblesNeeded(input int idx);
      bit exHit, memHit;
      exHit  = REGWRITE_ex  && reads(Rd_ex);
      memHit = REGWRITE_mem && reads(Rd_mem);
      if (idx == 0) return (exHit && MEMREAD_ex) ? 1 : 0;
      if (exHit)  return 2;
      if (memHit) return 1;
      return 0;
   endfunction

   function automatic logic [7:0] expected(input int idx);
      logic [7:0] e;
      e = 8'b0;
      if (!rst) return e;
      if (mHalt[idx]) begin
         e = 8'b1000_1101;
         if (dmem_busy) e = e | 8'b0001_0010;
      end else if (dmem_busy)                           e = 8'b1111_0010;
      else if (redirect_ex)                             e = 8'b0000_1100;
      else if (HALT_ex)                                 e = 8'b1000_1100;
      else if (mPend[idx] > 0 || bubblesNeeded(idx) > 0) e = 8'b1100_0100;
      return e;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mHalt[i] = 0; mPend[i] = 0; mCnt[i] = 0;
      end
   endtask

   // Advance the model by one clock edge using the inputs held across it.
   task automatic modelClock();
      logic [7:0] e;
      int n;
      if (!rst) return;
      for (int i = 0; i < 2; i++) begin
         e = expected(i);
         n = bubblesNeeded(i);
         if (e[7] && mCnt[i] < 15) mCnt[i]++;
         if (mHalt[i] || dmem_busy) continue;
         if (redirect_ex)      mPend[i] = 0;
         else if (HALT_ex)     begin mHalt[i] = 1; mPend[i] = 0; end
         else if (mPend[i] > 0) mPend[i]--;
         else if (n > 0)       mPend[i] = n - 1;
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [7:0] eF, eN;
      logic [3:0] cF, cN;
      eF = expected(0);
      eN = expected(1);
      cF = 4'(mCnt[0]);
      cN = 4'(mCnt[1]);
      vectors++;
      assert (outF === eF) else begin
         miscompares++;
         $error("[TB] FAIL %s fwd1 outputs observed=%b expected=%b", tag, outF, eF);
      end
      vectors++;
      assert (outN === eN) else begin
         miscompares++;
         $error("[TB] FAIL %s fwd0 outputs observed=%b expected=%b", tag, outN, eN);
      end
      vectors++;
      assert (cntF === cF) else begin
         miscompares++;
         $error("[TB] FAIL %s fwd1 stall_cycles observed=%0d expected=%0d", tag, cntF, cF);
      end
      vectors++;
      assert (cntN === cN) else begin
         miscompares++;
         $error("[TB] FAIL %s fwd0 stall_cycles observed=%0d expected=%0d", tag, cntN, cN);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] rs, input logic urs,
                                input logic [2:0] rt, input logic urt,
                                input logic [2:0] rdex, input logic rwex, input logic mrex,
                                input logic [2:0] rdmem, input logic rwmem,
                                input logic redir, input logic halt, input logic busy);
      Rs10_8_dec = rs;  uses_rs_dec = urs;
      Rt7_5_dec  = rt;  uses_rt_dec = urt;
      Rd_ex = rdex; REGWRITE_ex = rwex; MEMREAD_ex = mrex;
      Rd_mem = rdmem; REGWRITE_mem = rwmem;
      redirect_ex = redir; HALT_ex = halt; dmem_busy = busy;
   endtask

   task automatic idle();
      applyStimulus(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0);
   endtask

   // Called just after a rising edge: check mid-cycle, then cross the next edge.
   task automatic stepCycle(input string tag);
      @(negedge clk);
      checkOutput(tag);
      @(posedge clk);
      modelClock();
      #1;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic resetPulse(input string tag);
      #2;
      rst = 1'b0;
      #1;
      modelReset();
      checkOutput(tag);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      modelReset();
      idle();
      #3;
      checkOutput("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      stepCycle("idle");

      // Load r3 in EX, decode reads r3 as Rs.
      applyStimulus(3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 3'd0, 0, 0, 0, 0);
      stepCycle("loadUse");
      idle();
      stepCycle("loadUseAfter");
      stepCycle("loadUseAfter2");

      // ALU writes r2 in EX, decode reads r2 as Rt.
      applyStimulus(3'd0, 0, 3'd2, 1, 3'd2, 1, 0, 3'd0, 0, 0, 0, 0);
      stepCycle("aluEx1");
      idle();
      stepCycle("aluEx2");
      stepCycle("aluExDone");

      // Only MEM writes r2.
      applyStimulus(3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 3'd2, 1, 0, 0, 0);
      stepCycle("aluMem");
      idle();
      stepCycle("aluMemDone");

      // Memory wait arriving during a pending bubble.
      applyStimulus(3'd0, 0, 3'd2, 1, 3'd2, 1, 0, 3'd0, 0, 0, 0, 0);
      stepCycle("busyHaz");
      idle();
      dmem_busy = 1'b1;
      for (int i = 0; i < 3; i++) stepCycle("busyWait");
      dmem_busy = 1'b0;
      stepCycle("busyResume");
      stepCycle("busyDone");

      // Redirect together with a load-use match.
      applyStimulus(3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 3'd0, 0, 1, 0, 0);
      stepCycle("redirect");
      idle();
      stepCycle("redirectAfter");

      // HALT drain, then reset mid-HALTED.
      HALT_ex = 1'b1;
      stepCycle("haltEnter");
      idle();
      for (int i = 0; i < 12; i++) begin
         dmem_busy = (i == 5);
         stepCycle("halted");
      end
      idle();
      resetPulse("haltReset");
      stepCycle("postReset");

      // Counter saturation.
      dmem_busy = 1'b1;
      for (int i = 0; i < 21; i++) stepCycle("saturate");
      vectors++;
      assert (cntF === 4'hF && cntN === 4'hF) else begin
         miscompares++;
         $error("[TB] FAIL satHold observed=%0d/%0d expected=15/15", cntF, cntN);
      end
      idle();
      resetPulse("satReset");

      // Randomized traffic with small register space to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
                       1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                       1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
                       ($urandom_range(0, 4) == 0));
         stepCycle("rand");
         if (i % 60 == 59) resetPulse("randReset");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
